// File: rtl/ii_writer_19x19_pkg.sv
// Shared geometry, widths and controller states for the 19x19 integral-image writer.
package ii_writer_19x19_pkg;

  localparam int II_W     = 21;
  localparam int PIX_W    = 8;
  localparam int SUM_W    = 17;
  localparam int WIN      = 19;
  localparam int IIDIM    = 20;
  localparam int II_WORDS = 400;

  // Last column/row index of the 20x20 image and the index of its final word.
  localparam logic [4:0] LAST_COL  = 5'(IIDIM - 1);
  localparam logic [4:0] LAST_ROW  = 5'(IIDIM - 1);
  localparam logic [8:0] LAST_WORD = 9'(II_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    GAP,
    ZROW,
    ZCOL,
    PIX,
    DONE
  } state_t;

endpackage

// File: rtl/ii_writer_19x19_row_shift.sv
// ii_row_shift_19: 19-deep line of previous-row integral values.
// Entries are consumed in column order, so a plain shift register replaces addressed storage.
module ii_row_shift_19
  import ii_writer_19x19_pkg::*;
(
  input  logic             iClk,
  input  logic             iReset,
  input  logic             iClear,
  input  logic             iShift,
  input  logic [SUM_W-1:0] iTail,
  output logic [SUM_W-1:0] oHead
);

  logic [SUM_W-1:0] line [WIN];

  // Pop the head and append the new value at the tail; clear wipes the whole row.
  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      for (int i = 0; i < WIN; i++) line[i] <= '0;
    end else if (iClear) begin
      for (int i = 0; i < WIN; i++) line[i] <= '0;
    end else if (iShift) begin
      for (int i = 0; i < WIN - 1; i++) line[i] <= line[i+1];
      line[WIN-1] <= iTail;
    end
  end

  assign oHead = line[0];

endmodule

// File: rtl/ii_writer_19x19.sv
// ii_writer_19x19: turns a row-major 19x19 pixel stream into the 400-word zero-padded
// integral image and writes it into the integral-image buffer.
// Optional feature: define II_WRITER_SYNC_CHECK_EN to compare the buffer full flag
// against the word index on every write and raise a sticky oErr on misalignment.
module ii_writer_19x19
  import ii_writer_19x19_pkg::*;
(
  input  logic             iClk,
  input  logic             iReset,
  input  logic             iStart,
  input  logic             iPix_valid,
  input  logic [PIX_W-1:0] iPix,
  input  logic             iBuf_full,
  output logic             oPix_ready,
  output logic             oBuf_rst,
  output logic             oWrreq,
  output logic [II_W-1:0]  oData,
  output logic             oBusy,
  output logic             oDone,
  output logic             oErr
);

  state_t           state;
  state_t           nextState;
  logic [4:0]       colCnt;
  logic [4:0]       rowCnt;
  logic [SUM_W-1:0] rowSum;
  logic [SUM_W-1:0] sumNext;
  logic [SUM_W-1:0] lineHead;
  logic [SUM_W-1:0] wrValue;
  logic [SUM_W-1:0] issueData;
  logic             pixAcc;
  logic             issueWr;
  logic             lineClear;

  // Previous-row storage feeding the vertical term of each integral value.
  ii_row_shift_19 uLine (
    .iClk   (iClk),
    .iReset (iReset),
    .iClear (lineClear),
    .iShift (pixAcc),
    .iTail  (wrValue),
    .oHead  (lineHead)
  );

  // Controller state register.
  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) state <= IDLE;
    else        state <= nextState;
  end

  // Next-state logic plus the combinational write/handshake decode.
  always_comb begin
    nextState  = state;
    oPix_ready = 1'b0;
    pixAcc     = 1'b0;
    issueWr    = 1'b0;
    issueData  = '0;
    lineClear  = 1'b0;
    sumNext    = rowSum + {{(SUM_W-PIX_W){1'b0}}, iPix};
    wrValue    = lineHead + sumNext;
    unique case (state)
      IDLE: begin
        if (iStart) nextState = CLR;
      end
      CLR: begin
        lineClear = 1'b1;
        nextState = GAP;
      end
      GAP: begin
        nextState = ZROW;
      end
      ZROW: begin
        issueWr = 1'b1;
        if (colCnt == LAST_COL) nextState = ZCOL;
      end
      ZCOL: begin
        issueWr   = 1'b1;
        nextState = PIX;
      end
      PIX: begin
        oPix_ready = 1'b1;
        pixAcc     = iPix_valid;
        issueWr    = iPix_valid;
        issueData  = wrValue;
        if (iPix_valid && colCnt == LAST_COL) begin
          nextState = (rowCnt == LAST_ROW) ? DONE : ZCOL;
        end
      end
      DONE: begin
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // Row/column position and the running sum of the current pixel row.
  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      colCnt <= '0;
      rowCnt <= '0;
      rowSum <= '0;
    end else begin
      unique case (state)
        CLR: begin
          colCnt <= '0;
          rowCnt <= '0;
          rowSum <= '0;
        end
        ZROW: begin
          if (colCnt == LAST_COL) begin
            colCnt <= '0;
            rowCnt <= 5'd1;
          end else begin
            colCnt <= colCnt + 5'd1;
          end
        end
        ZCOL: begin
          rowSum <= '0;
          colCnt <= 5'd1;
        end
        PIX: begin
          if (pixAcc) begin
            rowSum <= sumNext;
            if (colCnt == LAST_COL) begin
              colCnt <= '0;
              rowCnt <= rowCnt + 5'd1;
            end else begin
              colCnt <= colCnt + 5'd1;
            end
          end
        end
        default: begin
          colCnt <= colCnt;
        end
      endcase
    end
  end

  // Registered buffer-side outputs: writes land one cycle after they are issued.
  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      oWrreq   <= 1'b0;
      oData    <= '0;
      oBuf_rst <= 1'b0;
      oBusy    <= 1'b0;
      oDone    <= 1'b0;
    end else begin
      oWrreq   <= issueWr;
      if (issueWr) oData <= {{(II_W-SUM_W){1'b0}}, issueData};
      oBuf_rst <= (nextState == CLR);
      oBusy    <= (nextState != IDLE);
      oDone    <= (state == DONE);
    end
  end

`ifdef II_WRITER_SYNC_CHECK_EN
  logic [8:0] wrCount;
  logic [8:0] outIdx;

  // Index of the word currently presented on oData, counted from the window start.
  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      wrCount <= '0;
      outIdx  <= '0;
    end else if (state == CLR) begin
      wrCount <= '0;
      outIdx  <= '0;
    end else if (issueWr) begin
      outIdx  <= wrCount;
      wrCount <= wrCount + 9'd1;
    end
  end

  // Sticky flag: buffer full must coincide exactly with the final word of the image.
  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      oErr <= 1'b0;
    end else if (nextState == CLR) begin
      oErr <= 1'b0;
    end else if (oWrreq && (iBuf_full != (outIdx == LAST_WORD))) begin
      oErr <= 1'b1;
    end
  end
`else
  logic unusedFull;
  assign unusedFull = iBuf_full;
  assign oErr       = 1'b0;
`endif

endmodule

// File: tb/tb_ii_writer_19x19.sv
// Self-checking bench for ii_writer_19x19: a golden integral-image model built from the
// pixel array, a per-cycle write scoreboard and directed timing/boundary checks.
module tb_ii_writer_19x19;

  logic        iClk = 1'b0;
  logic        iReset;
  logic        iStart;
  logic        iPix_valid;
  logic [7:0]  iPix;
  logic        iBuf_full = 1'b0;
  logic        oPix_ready;
  logic        oBuf_rst;
  logic        oWrreq;
  logic [20:0] oData;
  logic        oBusy;
  logic        oDone;
  logic        oErr;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int pix  [361];
  int gold [400];

  int wrSeen, firstWrCyc, lastWrCyc, doneCyc, doneCount, rstCount, bufWrites, lastData;
  bit errSeen;
  bit forceFull = 1'b0;

  ii_writer_19x19 dut (
    .iClk       (iClk),
    .iReset     (iReset),
    .iStart     (iStart),
    .iPix_valid (iPix_valid),
    .iPix       (iPix),
    .iBuf_full  (iBuf_full),
    .oPix_ready (oPix_ready),
    .oBuf_rst   (oBuf_rst),
    .oWrreq     (oWrreq),
    .oData      (oData),
    .oBusy      (oBusy),
    .oDone      (oDone),
    .oErr       (oErr)
  );

  always #5 iClk = ~iClk;

  always @(posedge iClk) cyc++;

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Integral image straight from its definition: sum of all pixels above-left of (r,c).
  task automatic computeGold();
    for (int r = 0; r < 20; r++)
      for (int c = 0; c < 20; c++) begin
        int s;
        s = 0;
        for (int i = 0; i < r; i++)
          for (int j = 0; j < c; j++)
            s += pix[i*19 + j];
        gold[r*20 + c] = s;
      end
  endtask

  // Scoreboard: every presented write is compared with the model in order; also plays the buffer.
  always @(negedge iClk) begin
    if (oBuf_rst) begin
      rstCount++;
      bufWrites = 0;
    end
    iBuf_full = (bufWrites >= 399) || (forceFull && bufWrites == 200);
    if (oWrreq) begin
      if (wrSeen < 400) checkOutput("writeData", int'(oData), gold[wrSeen]);
      else              checkOutput("writeOverrun", wrSeen, 399);
      checkOutput("dataTopBits", int'(oData[20:17]), 0);
      if (wrSeen == 399) lastData = int'(oData);
      if (wrSeen == 0) firstWrCyc = cyc;
      lastWrCyc = cyc;
      wrSeen++;
      bufWrites++;
    end
    if (oDone) begin
      doneCount++;
      doneCyc = cyc;
    end
    if (oErr) errSeen = 1'b1;
  end

  // One full window: start pulse, pixel stream with optional gaps, then timing checks.
  task automatic applyStimulus(input bit useGaps, input bit startMid, input bit expErr);
    int idx, gaps, cE, budget;
    bit valid;
    computeGold();
    wrSeen = 0; doneCount = 0; rstCount = 0;
    firstWrCyc = -1; lastWrCyc = -1; doneCyc = -1;
    @(negedge iClk); iStart = 1'b1;
    @(negedge iClk); iStart = 1'b0; cE = cyc;
    errSeen = 1'b0;
    checkOutput("bufRstAfterStart", int'(oBuf_rst), 1);
    checkOutput("busyAfterStart", int'(oBusy), 1);
    checkOutput("errClearedByClr", int'(oErr), 0);
    checkOutput("notReadyInClr", int'(oPix_ready), 0);
    idx = 0; gaps = 0; budget = 0;
    while (idx < 361 && budget < 4000) begin
      valid      = useGaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      iPix_valid = valid;
      iPix       = 8'(pix[idx]);
      iStart     = startMid && idx >= 100 && idx < 103;
      if (oPix_ready && valid) idx++;
      else if (oPix_ready)     gaps++;
      @(negedge iClk);
      budget++;
    end
    iPix_valid = 1'b0;
    iStart     = 1'b0;
    checkOutput("pixelsAccepted", idx, 361);
    budget = 0;
    while (doneCount == 0 && budget < 60) begin
      @(negedge iClk);
      budget++;
    end
    repeat (4) @(negedge iClk);
    checkOutput("writeCount", wrSeen, 400);
    checkOutput("firstWriteLatency", firstWrCyc - cE, 3);
    checkOutput("writeSpan", lastWrCyc - firstWrCyc + 1, 400 + gaps);
    checkOutput("doneAfterLastWrite", doneCyc - lastWrCyc, 1);
    checkOutput("donePulses", doneCount, 1);
    checkOutput("bufRstPulses", rstCount, 1);
    checkOutput("busyAfterDone", int'(oBusy), 0);
    checkOutput("errFinal", int'(oErr), int'(expErr));
    checkOutput("errSeen", int'(errSeen), int'(expErr));
  endtask

  // Abandon a window after 150 writes with an asynchronous reset.
  task automatic midReset();
    int idx, budget, reached;
    computeGold();
    wrSeen = 0;
    @(negedge iClk); iStart = 1'b1;
    @(negedge iClk); iStart = 1'b0;
    idx = 0; budget = 0;
    while (wrSeen < 150 && budget < 1000) begin
      iPix_valid = 1'b1;
      iPix       = 8'(pix[idx]);
      if (oPix_ready) idx++;
      @(negedge iClk);
      budget++;
    end
    reached = (wrSeen >= 150) ? 1 : 0;
    checkOutput("reachedWrite150", reached, 1);
    iReset = 1'b1;
    #1;
    checkOutput("rstWrreq", int'(oWrreq), 0);
    checkOutput("rstData", int'(oData), 0);
    checkOutput("rstBusy", int'(oBusy), 0);
    checkOutput("rstReady", int'(oPix_ready), 0);
    checkOutput("rstBufRst", int'(oBuf_rst), 0);
    checkOutput("rstDone", int'(oDone), 0);
    iPix_valid = 1'b0;
    @(negedge iClk);
    iReset = 1'b0;
    @(negedge iClk);
  endtask

  initial begin
    iReset = 1'b1; iStart = 1'b0; iPix_valid = 1'b0; iPix = '0;
    repeat (3) @(negedge iClk);
    checkOutput("resetReady", int'(oPix_ready), 0);
    checkOutput("resetBufRst", int'(oBuf_rst), 0);
    checkOutput("resetWrreq", int'(oWrreq), 0);
    checkOutput("resetData", int'(oData), 0);
    checkOutput("resetBusy", int'(oBusy), 0);
    checkOutput("resetDone", int'(oDone), 0);
    checkOutput("resetErr", int'(oErr), 0);
    iReset = 1'b0;
    repeat (2) @(negedge iClk);

    $display("[TB] window: all pixels 1");
    for (int i = 0; i < 361; i++) pix[i] = 1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("modelOnes_5_7", gold[5*20 + 7], 35);
    checkOutput("modelOnes_19_19", gold[399], 361);
    checkOutput("dutOnesWord399", lastData, 361);

    $display("[TB] window: all pixels 255");
    for (int i = 0; i < 361; i++) pix[i] = 255;
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("model255_19_19", gold[399], 92055);
    checkOutput("dut255Word399", lastData, 92055);

    $display("[TB] window: ramp with valid gaps");
    for (int i = 0; i < 361; i++) pix[i] = i % 256;
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("modelRamp_1_2", gold[1*20 + 2], 1);
    checkOutput("modelRamp_2_2", gold[2*20 + 2], 40);

    $display("[TB] window: iStart pulsed during pixels");
    applyStimulus(1'b1, 1'b1, 1'b0);

    $display("[TB] reset after 150 writes, then a fresh window");
    midReset();
    applyStimulus(1'b0, 1'b0, 1'b0);

`ifdef II_WRITER_SYNC_CHECK_EN
    $display("[TB] sync check: full flag raised at write 200");
    forceFull = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1);
    repeat (5) @(negedge iClk);
    checkOutput("errSticky", int'(oErr), 1);
    forceFull = 1'b0;
    $display("[TB] sync check: full flag only at write 399");
    applyStimulus(1'b1, 1'b0, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
